// File: rtl/riscv_pkg.sv
// RV32I decode vocabulary: opcodes, funct fields and the enumerations that
// describe a decoded instruction to the execute stage.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    localparam logic [2:0] F3_ADD_SUB  = 3'b000;
    localparam logic [2:0] F3_SLL      = 3'b001;
    localparam logic [2:0] F3_SLT      = 3'b010;
    localparam logic [2:0] F3_SLTU     = 3'b011;
    localparam logic [2:0] F3_XOR      = 3'b100;
    localparam logic [2:0] F3_SRL_SRA  = 3'b101;
    localparam logic [2:0] F3_OR       = 3'b110;
    localparam logic [2:0] F3_AND      = 3'b111;

    localparam logic [2:0] F3_BYTE     = 3'b000;
    localparam logic [2:0] F3_HALF     = 3'b001;
    localparam logic [2:0] F3_WORD     = 3'b010;
    localparam logic [2:0] F3_BYTE_U   = 3'b100;
    localparam logic [2:0] F3_HALF_U   = 3'b101;

    localparam logic [2:0] F3_FENCE    = 3'b000;
    localparam logic [2:0] F3_JALR     = 3'b000;

    localparam logic [6:0] F7_BASE     = 7'b0000000;
    localparam logic [6:0] F7_ALT      = 7'b0100000;

    localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_LUI   = 4'd10,
        ALU_AUIPC = 4'd11
    } alu_op_t;

    typedef enum logic [2:0] {
        CLASS_ALU    = 3'd0,
        CLASS_LOAD   = 3'd1,
        CLASS_STORE  = 3'd2,
        CLASS_BRANCH = 3'd3,
        CLASS_JAL    = 3'd4,
        CLASS_JALR   = 3'd5,
        CLASS_SYSTEM = 3'd6
    } op_class_t;

    // IMM_NONE marks words whose fields are not trusted at all (bad opcode).
    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_R    = 3'd1,
        IMM_I    = 3'd2,
        IMM_S    = 3'd3,
        IMM_B    = 3'd4,
        IMM_U    = 3'd5,
        IMM_J    = 3'd6
    } imm_format_t;

    typedef struct packed {
        op_class_t   opClass;
        alu_op_t     aluOp;
        imm_format_t immFormat;
        logic        regWrite;
        logic        illegal;
    } decode_t;

    function automatic alu_op_t aluFromFunct3(input logic [2:0] funct3, input logic alt);
        alu_op_t op;
        case (funct3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            F3_AND:     op = ALU_AND;
            default:    op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_immediate_generator.sv
// Sign-extended RV32I immediate for a given encoding format. The opcode bits
// carry no immediate information, so only instruction bits [31:7] come in.
module immediate_generator
    import riscv_pkg::*;
(
    input  logic [31:7] i_Instruction,
    input  imm_format_t i_Format,
    output logic [31:0] o_Immediate
);

    // Format-selected bit gather
    always_comb begin
        o_Immediate = 32'h0000_0000;
        case (i_Format)
            IMM_I: o_Immediate = {{20{i_Instruction[31]}}, i_Instruction[31:20]};
            IMM_S: o_Immediate = {{20{i_Instruction[31]}}, i_Instruction[31:25], i_Instruction[11:7]};
            IMM_B: o_Immediate = {{19{i_Instruction[31]}}, i_Instruction[31], i_Instruction[7],
                                  i_Instruction[30:25], i_Instruction[11:8], 1'b0};
            IMM_U: o_Immediate = {i_Instruction[31:12], 12'h000};
            IMM_J: o_Immediate = {{11{i_Instruction[31]}}, i_Instruction[31], i_Instruction[19:12],
                                  i_Instruction[20], i_Instruction[30:21], 1'b0};
            default: o_Immediate = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: a one-deep decode slot in front of execute that drives the
// register file read addresses and owns load-use stall and branch flush.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_Clock,
    input  logic            i_Reset_n,
    input  logic            i_FetchValid,
    input  logic [31:0]     i_Instruction,
    input  logic [XLEN-1:0] i_Pc,
    output logic            o_FetchReady,
    input  logic            i_ExecuteReady,
    input  logic            i_Flush,
    output logic [4:0]      o_RegSource1,
    output logic [4:0]      o_RegSource2,
    output logic            o_Valid,
    output logic [XLEN-1:0] o_Pc,
    output logic [4:0]      o_RegDest,
    output logic            o_RegWrite,
    output logic [XLEN-1:0] o_Immediate,
    output logic [3:0]      o_AluOp,
    output logic [2:0]      o_OpClass,
    output logic [2:0]      o_Funct3,
    output logic            o_Illegal
);

    logic [6:0]  w_Opcode;
    logic [2:0]  w_Funct3;
    logic [6:0]  w_Funct7;
    logic [4:0]  w_Rd;
    decode_t     w_Dec;
    logic        w_UsesRs1;
    logic        w_UsesRs2;
    logic [4:0]  w_InRs1;
    logic [4:0]  w_InRs2;
    logic [31:0] w_Immediate;
    logic        w_Hold;
    logic        w_LoadUse;
    logic        w_Transfer;
    logic [4:0]  r_HeldRs1;
    logic [4:0]  r_HeldRs2;

    assign w_Opcode = i_Instruction[6:0];
    assign w_Funct3 = i_Instruction[14:12];
    assign w_Funct7 = i_Instruction[31:25];
    assign w_Rd     = i_Instruction[11:7];

    // Opcode/funct decode; anything unrecognised falls through as an illegal ALU no-op
    always_comb begin
        w_Dec.opClass   = CLASS_ALU;
        w_Dec.aluOp     = ALU_ADD;
        w_Dec.immFormat = IMM_NONE;
        w_Dec.regWrite  = 1'b0;
        w_Dec.illegal   = 1'b1;
        case (w_Opcode)
            OPC_LUI: begin
                w_Dec.immFormat = IMM_U;
                w_Dec.aluOp     = ALU_LUI;
                w_Dec.regWrite  = 1'b1;
                w_Dec.illegal   = 1'b0;
            end
            OPC_AUIPC: begin
                w_Dec.immFormat = IMM_U;
                w_Dec.aluOp     = ALU_AUIPC;
                w_Dec.regWrite  = 1'b1;
                w_Dec.illegal   = 1'b0;
            end
            OPC_JAL: begin
                w_Dec.immFormat = IMM_J;
                w_Dec.opClass   = CLASS_JAL;
                w_Dec.regWrite  = 1'b1;
                w_Dec.illegal   = 1'b0;
            end
            OPC_JALR: begin
                w_Dec.immFormat = IMM_I;
                if (w_Funct3 == F3_JALR) begin
                    w_Dec.opClass  = CLASS_JALR;
                    w_Dec.regWrite = 1'b1;
                    w_Dec.illegal  = 1'b0;
                end else begin
                    w_Dec.illegal  = 1'b1;
                end
            end
            OPC_BRANCH: begin
                w_Dec.immFormat = IMM_B;
                if (w_Funct3 != 3'b010 && w_Funct3 != 3'b011) begin
                    w_Dec.opClass = CLASS_BRANCH;
                    w_Dec.illegal = 1'b0;
                end else begin
                    w_Dec.illegal = 1'b1;
                end
            end
            OPC_LOAD: begin
                w_Dec.immFormat = IMM_I;
                if (w_Funct3 == F3_BYTE || w_Funct3 == F3_HALF || w_Funct3 == F3_WORD ||
                    w_Funct3 == F3_BYTE_U || w_Funct3 == F3_HALF_U) begin
                    w_Dec.opClass  = CLASS_LOAD;
                    w_Dec.regWrite = 1'b1;
                    w_Dec.illegal  = 1'b0;
                end else begin
                    w_Dec.illegal  = 1'b1;
                end
            end
            OPC_STORE: begin
                w_Dec.immFormat = IMM_S;
                if (w_Funct3 == F3_BYTE || w_Funct3 == F3_HALF || w_Funct3 == F3_WORD) begin
                    w_Dec.opClass = CLASS_STORE;
                    w_Dec.illegal = 1'b0;
                end else begin
                    w_Dec.illegal = 1'b1;
                end
            end
            OPC_OPIMM: begin
                w_Dec.immFormat = IMM_I;
                // Only the shift-immediates constrain the upper bits
                if ((w_Funct3 == F3_SLL && w_Funct7 != F7_BASE) ||
                    (w_Funct3 == F3_SRL_SRA && w_Funct7 != F7_BASE && w_Funct7 != F7_ALT)) begin
                    w_Dec.illegal  = 1'b1;
                end else begin
                    w_Dec.aluOp    = aluFromFunct3(w_Funct3, (w_Funct3 == F3_SRL_SRA) && w_Funct7[5]);
                    w_Dec.regWrite = 1'b1;
                    w_Dec.illegal  = 1'b0;
                end
            end
            OPC_OP: begin
                w_Dec.immFormat = IMM_R;
                if ((w_Funct7 == F7_BASE) ||
                    (w_Funct7 == F7_ALT && (w_Funct3 == F3_ADD_SUB || w_Funct3 == F3_SRL_SRA))) begin
                    w_Dec.aluOp    = aluFromFunct3(w_Funct3, w_Funct7[5]);
                    w_Dec.regWrite = 1'b1;
                    w_Dec.illegal  = 1'b0;
                end else begin
                    w_Dec.illegal  = 1'b1;
                end
            end
            OPC_MISCMEM: begin
                w_Dec.immFormat = IMM_I;
                w_Dec.illegal   = (w_Funct3 != F3_FENCE);
            end
            OPC_SYSTEM: begin
                w_Dec.immFormat = IMM_I;
                if (i_Instruction == INSN_ECALL || i_Instruction == INSN_EBREAK) begin
                    w_Dec.opClass = CLASS_SYSTEM;
                    w_Dec.illegal = 1'b0;
                end else begin
                    w_Dec.illegal = 1'b1;
                end
            end
            default: begin
                w_Dec.illegal = 1'b1;
            end
        endcase
    end

    assign w_UsesRs1 = (w_Dec.immFormat == IMM_R) || (w_Dec.immFormat == IMM_I) ||
                       (w_Dec.immFormat == IMM_S) || (w_Dec.immFormat == IMM_B);
    assign w_UsesRs2 = (w_Dec.immFormat == IMM_R) || (w_Dec.immFormat == IMM_S) ||
                       (w_Dec.immFormat == IMM_B);
    assign w_InRs1   = w_UsesRs1 ? i_Instruction[19:15] : 5'd0;
    assign w_InRs2   = w_UsesRs2 ? i_Instruction[24:20] : 5'd0;

    immediate_generator u_immediateGenerator (
        .i_Instruction (i_Instruction[31:7]),
        .i_Format      (w_Dec.immFormat),
        .o_Immediate   (w_Immediate)
    );

    assign w_Hold = o_Valid && !i_ExecuteReady && !i_Flush;

    // Unused source fields are already forced to x0, so they can never match a nonzero rd
    assign w_LoadUse = o_Valid && (o_OpClass == CLASS_LOAD) && (o_RegDest != 5'd0) && i_FetchValid &&
                       ((w_UsesRs1 && w_InRs1 == o_RegDest) || (w_UsesRs2 && w_InRs2 == o_RegDest));

    assign o_FetchReady = !i_Flush && (!o_Valid || i_ExecuteReady) && !w_LoadUse;
    assign w_Transfer   = i_FetchValid && o_FetchReady;

    // The register file re-reads the held sources each stalled cycle so late writebacks land
    assign o_RegSource1 = w_Hold ? r_HeldRs1 : w_InRs1;
    assign o_RegSource2 = w_Hold ? r_HeldRs2 : w_InRs2;

    // Decode slot: capture on transfer, keep on hold, otherwise drain to a bubble
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_Valid     <= 1'b0;
            o_Pc        <= '0;
            o_RegDest   <= 5'd0;
            o_RegWrite  <= 1'b0;
            o_Immediate <= '0;
            o_AluOp     <= 4'd0;
            o_OpClass   <= 3'd0;
            o_Funct3    <= 3'd0;
            o_Illegal   <= 1'b0;
            r_HeldRs1   <= 5'd0;
            r_HeldRs2   <= 5'd0;
        end else if (w_Transfer) begin
            o_Valid     <= 1'b1;
            o_Pc        <= i_Pc;
            o_RegDest   <= w_Rd;
            o_RegWrite  <= w_Dec.regWrite && (w_Rd != 5'd0);
            o_Immediate <= w_Immediate;
            o_AluOp     <= w_Dec.aluOp;
            o_OpClass   <= w_Dec.opClass;
            o_Funct3    <= w_Funct3;
            o_Illegal   <= w_Dec.illegal;
            r_HeldRs1   <= w_InRs1;
            r_HeldRs2   <= w_InRs2;
        end else if (!w_Hold) begin
            o_Valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a decode table streamed back to back,
// then hand-written load-use, hold, flush and mid-stall reset sequences.
module tb_decode_stage;

    localparam logic [3:0] A_ADD   = 4'd0;
    localparam logic [3:0] A_SUB   = 4'd1;
    localparam logic [3:0] A_SRA   = 4'd7;
    localparam logic [3:0] A_LUI   = 4'd10;
    localparam logic [3:0] A_AUIPC = 4'd11;
    localparam logic [2:0] C_ALU   = 3'd0;
    localparam logic [2:0] C_LOAD  = 3'd1;
    localparam logic [2:0] C_STORE = 3'd2;
    localparam logic [2:0] C_BR    = 3'd3;
    localparam logic [2:0] C_JAL   = 3'd4;
    localparam logic [2:0] C_JALR  = 3'd5;
    localparam logic [2:0] C_SYS   = 3'd6;
    localparam int NV = 21;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [2:0]  cls;
        logic [2:0]  f3;
        logic        ill;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        vec_t        v;
    } exp_t;

    logic        clk;
    logic        rstN;
    logic        fetchValid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fetchReady;
    logic        execReady;
    logic        flush;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        valid;
    logic [31:0] oPc;
    logic [4:0]  rd;
    logic        regWrite;
    logic [31:0] imm;
    logic [3:0]  aluOp;
    logic [2:0]  opClass;
    logic [2:0]  funct3;
    logic        illegal;

    int   nCmp = 0;
    int   nBad = 0;
    exp_t sb[$];
    vec_t tbl[NV];
    vec_t noVec;

    decode_stage dut (
        .i_Clock        (clk),
        .i_Reset_n      (rstN),
        .i_FetchValid   (fetchValid),
        .i_Instruction  (instr),
        .i_Pc           (pc),
        .o_FetchReady   (fetchReady),
        .i_ExecuteReady (execReady),
        .i_Flush        (flush),
        .o_RegSource1   (rs1),
        .o_RegSource2   (rs2),
        .o_Valid        (valid),
        .o_Pc           (oPc),
        .o_RegDest      (rd),
        .o_RegWrite     (regWrite),
        .o_Immediate    (imm),
        .o_AluOp        (aluOp),
        .o_OpClass      (opClass),
        .o_Funct3       (funct3),
        .o_Illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [31:0] i, input logic [4:0] s1, input logic [4:0] s2,
                                input logic [4:0] d, input logic w, input logic [31:0] im,
                                input logic [3:0] a, input logic [2:0] c, input logic [2:0] f,
                                input logic il);
        vec_t v;
        v.instr = i; v.rs1 = s1; v.rs2 = s2; v.rd = d; v.rw = w;
        v.imm = im; v.alu = a; v.cls = c; v.f3 = f; v.ill = il;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fv, input logic [31:0] ins, input logic [31:0] p,
                         input logic er, input logic fl);
        fetchValid = fv; instr = ins; pc = p; execReady = er; flush = fl;
    endtask

    task automatic push(input logic vld, input logic [31:0] p, input vec_t v);
        exp_t e;
        e.valid = vld; e.pc = p; e.v = v;
        sb.push_back(e);
    endtask

    task automatic check_ports(input string name, input logic expReady, input vec_t v);
        chk({name, "_ready"}, 32'(fetchReady), 32'(expReady));
        chk({name, "_rs1"}, 32'(rs1), 32'(v.rs1));
        chk({name, "_rs2"}, 32'(rs2), 32'(v.rs2));
    endtask

    task automatic check_slot(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            nCmp++; nBad++;
            $display("FAIL %s_scoreboard: got empty queue, expected an entry", name);
        end else begin
            e = sb.pop_front();
            chk({name, "_valid"}, 32'(valid), 32'(e.valid));
            if (e.valid) begin
                chk({name, "_pc"}, oPc, e.pc);
                chk({name, "_rd"}, 32'(rd), 32'(e.v.rd));
                chk({name, "_rw"}, 32'(regWrite), 32'(e.v.rw));
                chk({name, "_imm"}, imm, e.v.imm);
                chk({name, "_alu"}, 32'(aluOp), 32'(e.v.alu));
                chk({name, "_class"}, 32'(opClass), 32'(e.v.cls));
                chk({name, "_f3"}, 32'(funct3), 32'(e.v.f3));
                chk({name, "_illegal"}, 32'(illegal), 32'(e.v.ill));
            end
        end
    endtask

    task automatic check_reset(input string name);
        chk({name, "_valid"}, 32'(valid), 32'd0);
        chk({name, "_pc"}, oPc, 32'd0);
        chk({name, "_rd"}, 32'(rd), 32'd0);
        chk({name, "_rw"}, 32'(regWrite), 32'd0);
        chk({name, "_imm"}, imm, 32'd0);
        chk({name, "_alu"}, 32'(aluOp), 32'd0);
        chk({name, "_class"}, 32'(opClass), 32'd0);
        chk({name, "_f3"}, 32'(funct3), 32'd0);
        chk({name, "_illegal"}, 32'(illegal), 32'd0);
        chk({name, "_ready"}, 32'(fetchReady), 32'd1);
    endtask

    // One cycle: offer v at the negedge, check ready/addresses, then the slot after the edge
    task automatic cycle(input string name, input vec_t v, input logic [31:0] p, input logic er,
                         input logic fl, input logic expReady, input vec_t expAddr,
                         input logic expValid, input logic [31:0] expPc, input vec_t expSlot);
        @(negedge clk);
        drive(1'b1, v.instr, p, er, fl);
        #1;
        check_ports(name, expReady, expAddr);
        push(expValid, expPc, expSlot);
        @(posedge clk);
        #1;
        check_slot(name);
    endtask

    task automatic load_use_pair(input string name, input vec_t ld, input vec_t usr, input logic [31:0] p);
        cycle({name, "_load"}, ld, p, 1'b1, 1'b0, 1'b1, ld, 1'b1, p, ld);
        cycle({name, "_stall"}, usr, p + 32'd4, 1'b1, 1'b0, 1'b0, usr, 1'b0, 32'd0, noVec);
        cycle({name, "_retry"}, usr, p + 32'd4, 1'b1, 1'b0, 1'b1, usr, 1'b1, p + 32'd4, usr);
    endtask

    initial begin
        noVec = mk(32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 4'd0, 3'd0, 3'd0, 1'b0);
        tbl[0]  = mk(32'hFFF00293, 5'd0,  5'd0,  5'd5,  1'b1, 32'hFFFFFFFF, A_ADD,   C_ALU,   3'd0, 1'b0); // addi x5,x0,-1
        tbl[1]  = mk(32'h002303B3, 5'd6,  5'd2,  5'd7,  1'b1, 32'h00000000, A_ADD,   C_ALU,   3'd0, 1'b0); // add x7,x6,x2
        tbl[2]  = mk(32'h40C58533, 5'd11, 5'd12, 5'd10, 1'b1, 32'h00000000, A_SUB,   C_ALU,   3'd0, 1'b0); // sub x10,x11,x12
        tbl[3]  = mk(32'h0000A303, 5'd1,  5'd0,  5'd6,  1'b1, 32'h00000000, A_ADD,   C_LOAD,  3'd2, 1'b0); // lw x6,0(x1)
        tbl[4]  = mk(32'hABCDE1B7, 5'd0,  5'd0,  5'd3,  1'b1, 32'hABCDE000, A_LUI,   C_ALU,   3'd6, 1'b0); // lui
        tbl[5]  = mk(32'h00512423, 5'd2,  5'd5,  5'd8,  1'b0, 32'h00000008, A_ADD,   C_STORE, 3'd2, 1'b0); // sw x5,8(x2)
        tbl[6]  = mk(32'hFE000EE3, 5'd0,  5'd0,  5'd29, 1'b0, 32'hFFFFFFFC, A_ADD,   C_BR,    3'd0, 1'b0); // beq -4
        tbl[7]  = mk(32'h001000EF, 5'd0,  5'd0,  5'd1,  1'b1, 32'h00000800, A_ADD,   C_JAL,   3'd0, 1'b0); // jal x1,+2048
        tbl[8]  = mk(32'h00008067, 5'd1,  5'd0,  5'd0,  1'b0, 32'h00000000, A_ADD,   C_JALR,  3'd0, 1'b0); // jalr x0,0(x1)
        tbl[9]  = mk(32'h00100073, 5'd0,  5'd0,  5'd0,  1'b0, 32'h00000001, A_ADD,   C_SYS,   3'd0, 1'b0); // ebreak
        tbl[10] = mk(32'h00000073, 5'd0,  5'd0,  5'd0,  1'b0, 32'h00000000, A_ADD,   C_SYS,   3'd0, 1'b0); // ecall
        tbl[11] = mk(32'h0FF0000F, 5'd0,  5'd0,  5'd0,  1'b0, 32'h000000FF, A_ADD,   C_ALU,   3'd0, 1'b0); // fence
        tbl[12] = mk(32'hFFFFFFFF, 5'd0,  5'd0,  5'd31, 1'b0, 32'h00000000, A_ADD,   C_ALU,   3'd7, 1'b1); // bad opcode
        tbl[13] = mk(32'h02628233, 5'd5,  5'd6,  5'd4,  1'b0, 32'h00000000, A_ADD,   C_ALU,   3'd0, 1'b1); // mul (no M)
        tbl[14] = mk(32'h00000013, 5'd0,  5'd0,  5'd0,  1'b0, 32'h00000000, A_ADD,   C_ALU,   3'd0, 1'b0); // nop, rd=x0
        tbl[15] = mk(32'h4034D413, 5'd9,  5'd0,  5'd8,  1'b1, 32'h00000403, A_SRA,   C_ALU,   3'd5, 1'b0); // srai x8,x9,3
        tbl[16] = mk(32'h12345117, 5'd0,  5'd0,  5'd2,  1'b1, 32'h12345000, A_AUIPC, C_ALU,   3'd5, 1'b0); // auipc
        tbl[17] = mk(32'h00209863, 5'd1,  5'd2,  5'd16, 1'b0, 32'h00000010, A_ADD,   C_BR,    3'd1, 1'b0); // bne +16
        tbl[18] = mk(32'h0000B303, 5'd1,  5'd0,  5'd6,  1'b0, 32'h00000000, A_ADD,   C_ALU,   3'd3, 1'b1); // ld (illegal)
        tbl[19] = mk(32'h0000A003, 5'd1,  5'd0,  5'd0,  1'b0, 32'h00000000, A_ADD,   C_LOAD,  3'd2, 1'b0); // lw x0,0(x1)
        tbl[20] = mk(32'h002003B3, 5'd0,  5'd2,  5'd7,  1'b1, 32'h00000000, A_ADD,   C_ALU,   3'd0, 1'b0); // add x7,x0,x2

        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        rstN = 1'b1;
        #2 rstN = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rstN = 1'b1;

        // Back-to-back stream; a load into x0 must not stall the following reader of x0
        for (int i = 0; i < NV; i++) begin
            cycle($sformatf("vec%0d", i), tbl[i], 32'h1000 + 32'(i * 4), 1'b1, 1'b0,
                  1'b1, tbl[i], 1'b1, 32'h1000 + 32'(i * 4), tbl[i]);
        end

        load_use_pair("lu_rs1", tbl[3], tbl[1], 32'h2000);
        load_use_pair("lu_rs2", tbl[3], mk(32'h00612423, 5'd2, 5'd6, 5'd8, 1'b0, 32'h00000008,
                                         A_ADD, C_STORE, 3'd2, 1'b0), 32'h2100);

        // Hold an ADD for three cycles: addresses follow the held instruction, not fetch
        cycle("hold_in", tbl[1], 32'h2200, 1'b1, 1'b0, 1'b1, tbl[1], 1'b1, 32'h2200, tbl[1]);
        for (int k = 0; k < 3; k++) begin
            cycle($sformatf("hold%0d", k), tbl[2], 32'h2204, 1'b0, 1'b0, 1'b0, tbl[1],
                  1'b1, 32'h2200, tbl[1]);
        end
        cycle("hold_out", tbl[2], 32'h2204, 1'b1, 1'b0, 1'b1, tbl[2], 1'b1, 32'h2204, tbl[2]);

        // Flush with execute stalled still empties the slot and refuses the incoming word
        cycle("flush", tbl[0], 32'h2300, 1'b0, 1'b1, 1'b0, tbl[0], 1'b0, 32'd0, noVec);
        cycle("after_flush", tbl[0], 32'h2304, 1'b1, 1'b0, 1'b1, tbl[0], 1'b1, 32'h2304, tbl[0]);

        // Reset in the middle of a hold clears the slot without waiting for a clock edge
        cycle("pre_reset", tbl[2], 32'h4000, 1'b1, 1'b0, 1'b1, tbl[2], 1'b1, 32'h4000, tbl[2]);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        #2 rstN = 1'b0;
        #1 check_reset("midreset");
        sb.delete();
        @(negedge clk);
        rstN = 1'b1;
        cycle("post_reset", tbl[0], 32'h4004, 1'b1, 1'b0, 1'b1, tbl[0], 1'b1, 32'h4004, tbl[0]);

        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

RV32I instruction decode stage that sits directly upstream of the register file. It accepts fetched instructions over a valid/ready handshake and drives the register file source addresses. It registers the decoded control fields, so they reach execute in the same cycle as the register file's registered operands. It also owns load-use stall insertion and branch flush of the decode slot.

## Interface
- `XLEN`, default 32: instruction/PC/immediate width; only 32 is supported.
- `i_Clock` in 1: sole clock; all state on its rising edge.
- `i_Reset_n` in 1: asynchronous, active-low reset.
- `i_FetchValid` in 1: fetch offers `i_Instruction`/`i_Pc`.
- `i_Instruction` in 32: raw instruction word.
- `i_Pc` in 32: PC of `i_Instruction`.
- `o_FetchReady` out 1: decode accepts this cycle (combinational).
- `i_ExecuteReady` in 1: execute consumes the decode slot this cycle.
- `i_Flush` in 1: taken branch/jump; kill decode slot and incoming word.
- `o_RegSource1`, `o_RegSource2` out 5: register file read addresses (combinational).
- `o_Valid` out 1: decode slot holds a live instruction.
- `o_Pc` out 32: PC of held instruction.
- `o_RegDest` out 5: rd.
- `o_RegWrite` out 1: instruction writes rd; forced 0 when rd = x0.
- `o_Immediate` out 32: sign-extended immediate.
- `o_AluOp` out 4: `alu_op_t` encoding.
- `o_OpClass` out 3: `op_class_t` (ALU, LOAD, STORE, BRANCH, JAL, JALR, SYSTEM).
- `o_Funct3` out 3: passthrough for load/store size and branch condition.
- `o_Illegal` out 1: unrecognised opcode/funct; instruction still flows with `o_RegWrite` = 0.

## Operation
- Transfer: `i_FetchValid && o_FetchReady`. Decoded fields are captured into the slot registers; `o_Valid` <= 1.
- `o_FetchReady` = `!i_Flush && (!o_Valid || i_ExecuteReady) && !w_LoadUse`.
- Slot advance with no transfer: `o_Valid` <= 0. The slot then holds a bubble and other fields are don't-care.
- Hold: `o_Valid && !i_ExecuteReady && !i_Flush`. All slot registers are unchanged.
- Read address mux:
  - While holding, `o_RegSource1/2` = held rs1/rs2. The register file re-reads every cycle, so operands pick up writebacks that land during the stall.
  - Otherwise, they come from the `i_Instruction` rs fields.
  - Fields unused by the format (U/J for both, I for rs2) drive 0.
- `w_LoadUse` = `o_Valid && held OpClass == LOAD && held rd != 0 && i_FetchValid && (incoming uses rs1 and rs1 == rd, or uses rs2 and rs2 == rd)`.
  - When `w_LoadUse` is set and execute is ready, the load leaves and a bubble enters (`o_Valid` <= 0). Exactly one bubble is inserted.
- Flush has the highest priority: `o_Valid` <= 0, no transfer, and the incoming word is discarded by fetch.
- Immediates:
  - I: sext [31:20].
  - S: sext {[31:25],[11:7]}.
  - B: sext {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: sext {[31],[19:12],[20],[30:21],0}.
- FENCE decodes as an ALU no-op with `o_RegWrite` = 0. ECALL/EBREAK decode as SYSTEM with `o_RegWrite` = 0.

## Timing
- Reset: `o_Valid`, `o_Pc`, `o_RegDest`, `o_RegWrite`, `o_Immediate`, `o_AluOp`, `o_OpClass`, `o_Funct3`, `o_Illegal` = 0. `o_FetchReady` = 1 when `i_Flush` = 0.
- Latency: 1 cycle. An instruction accepted at edge N appears on the slot outputs after edge N. The register file operands are valid in that same cycle.
- Throughput: 1 per cycle absent stalls.
- Reset mid-stall empties the slot immediately, asynchronously.
- `i_Flush` together with `i_ExecuteReady` = 0 still empties the slot.

## Structure
- `riscv_pkg`: opcode constants, `alu_op_t`, `op_class_t`, `imm_format_t`, funct3 constants.
- Sub-module `immediate_generator`: combinational, takes instruction + `imm_format_t`, outputs 32-bit immediate.

## Test plan
- ADDI x5,x0,-1 (0xFFF00293) accepted, execute ready -> next cycle `o_Valid`=1, `o_RegDest`=5, `o_Immediate`=0xFFFFFFFF, `o_RegWrite`=1, `o_RegSource1`=0 at accept.
- LW x6,0(x1), then ADD x7,x6,x2 offered -> `o_FetchReady`=0 one cycle, one bubble, ADD accepted the following cycle.
- ADD held with `i_ExecuteReady`=0 for 3 cycles -> outputs stable, `o_RegSource1/2` equal held rs1/rs2.
- BEQ immediate -4 (0xFE000EE3) -> `o_Immediate`=0xFFFFFFFC, `o_OpClass`=BRANCH, `o_RegWrite`=0.
- `i_Flush`=1 with slot valid and fetch valid -> `o_FetchReady`=0, `o_Valid`=0 next cycle.
- Reset asserted with slot valid and held -> all outputs 0 immediately; first post-reset instruction decodes normally.
